// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder.
// Load/store funct3 codes, FSM encoding and funct3 legality helpers.
package dmem_pkg;

   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   typedef logic [1:0] state_t;

   localparam state_t IDLE = 2'd0;
   localparam state_t WAIT = 2'd1;
   localparam state_t RESP = 2'd2;

   function automatic logic storeF3Ok(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
   endfunction

   function automatic logic loadF3Ok(input logic [2:0] f3);
      return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
             (f3 == F3_BU) || (f3 == F3_HU);
   endfunction

endpackage

// File: rtl/dmem_responder_store_lane_gen.sv
// Store lane steering: byte enables, replicated lane data
// and the alignment check for half/word accesses.
module store_lane_gen
   import dmem_pkg::*;
(
   input  logic [2:0]  funct3,
   input  logic [1:0]  addrLo,
   input  logic [31:0] wdata,
   output logic [3:0]  be,
   output logic [31:0] laneData,
   output logic        alignErr
);

   // Decode access size into enables, lane data and alignment fault
   always_comb begin
      be       = 4'b0000;
      laneData = 32'h0;
      alignErr = 1'b0;
      unique case (funct3)
         F3_B, F3_BU: begin
            be       = 4'b0001 << addrLo;
            laneData = {4{wdata[7:0]}};
         end
         F3_H, F3_HU: begin
            be       = addrLo[1] ? 4'b1100 : 4'b0011;
            laneData = {2{wdata[15:0]}};
            alignErr = addrLo[0];
         end
         F3_W: begin
            be       = 4'b1111;
            laneData = wdata;
            alignErr = (addrLo != 2'b00);
         end
         default: begin
            be       = 4'b0000;
            laneData = 32'h0;
            alignErr = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, optional
// wait states, byte-lane stores and aligned word loads.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH       = 1024,
   parameter int WAIT_CYCLES = 0
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [2:0]  req_funct3,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err
);

   localparam int ADDR_W = $clog2(DEPTH);

   state_t      state;
   logic [3:0]  waitCnt;
   logic        weQ;
   logic [2:0]  f3Q;
   logic [31:0] addrQ;
   logic [31:0] wdataQ;

   logic [31:0] mem [DEPTH];

   logic [3:0]        be;
   logic [31:0]       laneData;
   logic              alignErr;
   logic              rangeErr;
   logic              f3Err;
   logic              accErr;
   logic              commit;
   logic [ADDR_W-1:0] wordIdx;

   store_lane_gen uLane (
      .funct3   (f3Q),
      .addrLo   (addrQ[1:0]),
      .wdata    (wdataQ),
      .be       (be),
      .laneData (laneData),
      .alignErr (alignErr)
   );

   assign wordIdx  = addrQ[ADDR_W+1:2];
   assign rangeErr = (addrQ >> (ADDR_W + 2)) != 32'h0;
   assign f3Err    = weQ ? !storeF3Ok(f3Q) : !loadF3Ok(f3Q);
   assign accErr   = rangeErr || f3Err || alignErr;
   assign commit   = (state == WAIT) && (waitCnt == 4'd0);

   assign req_ready  = (state == IDLE);
   assign resp_valid = (state == RESP);

   // Request latch, wait countdown, response registers and FSM
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         waitCnt    <= 4'd0;
         weQ        <= 1'b0;
         f3Q        <= 3'b000;
         addrQ      <= 32'h0;
         wdataQ     <= 32'h0;
         resp_rdata <= 32'h0;
         resp_err   <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  weQ     <= req_we;
                  f3Q     <= req_funct3;
                  addrQ   <= req_addr;
                  wdataQ  <= req_wdata;
                  waitCnt <= 4'(WAIT_CYCLES);
                  state   <= WAIT;
               end
            end
            WAIT: begin
               if (waitCnt == 4'd0) begin
                  state    <= RESP;
                  resp_err <= accErr;
                  if (!weQ && !accErr)
                     resp_rdata <= mem[wordIdx];
                  else
                     resp_rdata <= 32'h0;
               end else begin
                  waitCnt <= waitCnt - 4'd1;
               end
            end
            RESP: begin
               if (resp_ready)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Byte-enabled array write on the committing edge
   always_ff @(posedge clk) begin
      if (commit && weQ && !accErr) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i])
               mem[wordIdx][8*i +: 8] <= laneData[8*i +: 8];
         end
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a zero-wait and a
// three-wait instance, directed load/store vectors.
module tb_dmem_responder;

   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
   } exp_t;

   logic        clk;
   logic        rstN      [2];
   logic        reqValid  [2];
   logic        reqReady  [2];
   logic        reqWe     [2];
   logic [2:0]  reqF3     [2];
   logic [31:0] reqAddr   [2];
   logic [31:0] reqWdata  [2];
   logic        respValid [2];
   logic        respReady [2];
   logic [31:0] respRdata [2];
   logic        respErr   [2];

   exp_t q0[$];
   exp_t q1[$];

   int total = 0;
   int bad   = 0;

   dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(0)) dut0 (
      .clk        (clk),
      .reset      (rstN[0]),
      .req_valid  (reqValid[0]),
      .req_ready  (reqReady[0]),
      .req_we     (reqWe[0]),
      .req_funct3 (reqF3[0]),
      .req_addr   (reqAddr[0]),
      .req_wdata  (reqWdata[0]),
      .resp_valid (respValid[0]),
      .resp_ready (respReady[0]),
      .resp_rdata (respRdata[0]),
      .resp_err   (respErr[0])
   );

   dmem_responder #(.DEPTH(1024), .WAIT_CYCLES(3)) dut1 (
      .clk        (clk),
      .reset      (rstN[1]),
      .req_valid  (reqValid[1]),
      .req_ready  (reqReady[1]),
      .req_we     (reqWe[1]),
      .req_funct3 (reqF3[1]),
      .req_addr   (reqAddr[1]),
      .req_wdata  (reqWdata[1]),
      .resp_valid (respValid[1]),
      .resp_ready (respReady[1]),
      .resp_rdata (respRdata[1]),
      .resp_err   (respErr[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   // monitor: pop and compare on every response handshake
   always @(negedge clk) begin
      exp_t e;
      for (int d = 0; d < 2; d++) begin
         if (rstN[d] && respValid[d] && respReady[d]) begin
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
               chk($sformatf("dut%0d unexpected resp", d), 32'd1, 32'd0);
            end else begin
               e = (d == 0) ? q0.pop_front() : q1.pop_front();
               chk($sformatf("dut%0d rdata", d), respRdata[d], e.rdata);
               chk($sformatf("dut%0d err", d), {31'h0, respErr[d]},
                   {31'h0, e.err});
            end
         end
      end
   end

   task automatic issue(input int d, input logic we,
                        input logic [2:0] f3,
                        input logic [31:0] addr,
                        input logic [31:0] wdata,
                        input logic [31:0] expRdata,
                        input logic expErr,
                        input int hold);
      int n;
      int lat;
      int w;
      exp_t e;
      w = (d == 0) ? 0 : 3;
      e.rdata = expRdata;
      e.err   = expErr;
      if (d == 0) q0.push_back(e);
      else        q1.push_back(e);
      @(negedge clk);
      reqWe[d]    = we;
      reqF3[d]    = f3;
      reqAddr[d]  = addr;
      reqWdata[d] = wdata;
      reqValid[d] = 1'b1;
      respReady[d] = (hold == 0);
      n = 0;
      while (!reqReady[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept timeout", n < 50 ? 32'd0 : 32'd1, 32'd0);
      @(posedge clk);
      @(negedge clk);
      reqValid[d] = 1'b0;
      lat = 1;
      while (!respValid[d] && lat < 50) begin
         @(negedge clk);
         lat++;
      end
      chk($sformatf("dut%0d latency", d), lat, w + 2);
      if (hold != 0) begin
         for (int i = 0; i < hold; i++) begin
            chk("hold valid", {31'h0, respValid[d]}, 32'd1);
            chk("hold rdata", respRdata[d], expRdata);
            chk("hold err", {31'h0, respErr[d]}, {31'h0, expErr});
            chk("hold req_ready", {31'h0, reqReady[d]}, 32'd0);
            @(negedge clk);
         end
         @(posedge clk);
         #1 respReady[d] = 1'b1;
      end
      @(posedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout: got running want finished");
      $fatal(1, "timeout");
   end

   initial begin
      for (int d = 0; d < 2; d++) begin
         rstN[d]      = 1'b0;
         reqValid[d]  = 1'b0;
         reqWe[d]     = 1'b0;
         reqF3[d]     = 3'b000;
         reqAddr[d]   = 32'h0;
         reqWdata[d]  = 32'h0;
         respReady[d] = 1'b1;
      end
      #12;
      for (int d = 0; d < 2; d++) begin
         chk("reset req_ready", {31'h0, reqReady[d]}, 32'd1);
         chk("reset resp_valid", {31'h0, respValid[d]}, 32'd0);
         chk("reset rdata", respRdata[d], 32'h0);
         chk("reset err", {31'h0, respErr[d]}, 32'd0);
      end
      @(negedge clk);
      rstN[0] = 1'b1;
      rstN[1] = 1'b1;

      issue(0, 1, 3'b010, 32'h10, 32'hDEADBEEF, 32'h0, 0, 0);
      issue(0, 0, 3'b010, 32'h10, 32'h0, 32'hDEADBEEF, 0, 0);
      issue(0, 1, 3'b010, 32'h20, 32'h11223344, 32'h0, 0, 0);
      issue(0, 1, 3'b000, 32'h22, 32'h000000AA, 32'h0, 0, 0);
      issue(0, 1, 3'b001, 32'h20, 32'h00005566, 32'h0, 0, 0);
      issue(0, 0, 3'b010, 32'h20, 32'h0, 32'h11AA5566, 0, 0);
      issue(0, 1, 3'b001, 32'h21, 32'hFFFFFFFF, 32'h0, 1, 0);
      issue(0, 0, 3'b010, 32'h22, 32'h0, 32'h0, 1, 0);
      issue(0, 0, 3'b010, 32'h20, 32'h0, 32'h11AA5566, 0, 0);
      issue(0, 0, 3'b010, 32'h1000, 32'h0, 32'h0, 1, 0);
      issue(0, 1, 3'b011, 32'h20, 32'hFFFFFFFF, 32'h0, 1, 0);
      issue(0, 0, 3'b011, 32'h20, 32'h0, 32'h0, 1, 0);
      issue(0, 0, 3'b100, 32'h23, 32'h0, 32'h11AA5566, 0, 0);
      issue(0, 0, 3'b001, 32'h22, 32'h0, 32'h11AA5566, 0, 0);
      issue(0, 1, 3'b000, 32'h21, 32'h12345677, 32'h0, 0, 0);
      issue(0, 0, 3'b010, 32'h20, 32'h0, 32'h11AA7766, 0, 0);

      issue(1, 1, 3'b010, 32'h30, 32'h0, 32'h0, 0, 0);
      issue(1, 0, 3'b010, 32'h30, 32'h0, 32'h0, 0, 5);
      issue(1, 1, 3'b010, 32'h34, 32'h12345678, 32'h0, 0, 0);
      issue(1, 0, 3'b010, 32'h34, 32'h0, 32'h12345678, 0, 0);

      @(negedge clk);
      reqWe[1]    = 1'b1;
      reqF3[1]    = 3'b010;
      reqAddr[1]  = 32'h30;
      reqWdata[1] = 32'hCAFEF00D;
      reqValid[1] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reqValid[1] = 1'b0;
      @(negedge clk);
      rstN[1] = 1'b0;
      #1;
      chk("mid reset req_ready", {31'h0, reqReady[1]}, 32'd1);
      chk("mid reset resp_valid", {31'h0, respValid[1]}, 32'd0);
      @(negedge clk);
      rstN[1] = 1'b1;
      issue(1, 0, 3'b010, 32'h30, 32'h0, 32'h0, 0, 0);

      repeat (3) @(negedge clk);
      chk("q0 drained", q0.size(), 32'd0);
      chk("q1 drained", q1.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
